// File: rtl/regfile_wport_arbiter.sv
// regfile_wport_arbiter
// Shares the single register-file write port between the in-order WB stage and
// an out-of-band multi-cycle unit (MDU). It keeps a scoreboard of destinations
// with an MDU op in flight and raises RAW/WAW hazards to decode.
// The register file samples the port on its negedge, so the port is combinational.
// Optional starvation guard: define REGARB_STARVE_GUARD_EN to add a wait counter
// that freezes the pipeline and gives the MDU priority after MAX_WAIT refusals.
module regfile_wport_arbiter #(
  parameter int MAX_WAIT = 4,
  parameter int CNT_W    = 4
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        wb_we_i,
  input  logic [4:0]  wb_rd_i,
  input  logic [31:0] wb_data_i,
  input  logic        mdu_valid_i,
  input  logic [4:0]  mdu_rd_i,
  input  logic [31:0] mdu_data_i,
  output logic        mdu_ready_o,
  input  logic        issue_i,
  input  logic [4:0]  issue_rd_i,
  input  logic [4:0]  rs_i,
  input  logic [4:0]  rt_i,
  output logic        hazard_o,
  output logic        stall_o,
  output logic        RegWrite_o,
  output logic [4:0]  WriteReg_o,
  output logic [31:0] WriteData_o,
  output logic [31:0] pending_o
);

  // Configurations whose counter cannot reach MAX_WAIT elaborate this marker block.
  if (MAX_WAIT < 1 || MAX_WAIT > 15 || MAX_WAIT >= (1 << CNT_W)) begin : g_bad_params
  end

  logic        wbReq;
  logic        mduReq;
  logic        prioActive;
  logic        grantWb;
  logic        grantMdu;
  logic        stallInt;
  logic        mduXfer;
  logic        hazardInt;
  logic        issueAccept;
  logic        portWe;
  logic [4:0]  portReg;
  logic [31:0] portData;
  logic [31:0] pending_q;
  logic [31:0] pending_d;

  // Effective requests: a WB write to r0 is a no-op and never competes for the port.
  always_comb begin
    wbReq  = wb_we_i & (wb_rd_i != 5'd0);
    mduReq = mdu_valid_i;
  end

`ifdef REGARB_STARVE_GUARD_EN
  localparam logic [CNT_W-1:0] WaitMax = CNT_W'(MAX_WAIT);

  logic [CNT_W-1:0] waitCnt_q;
  logic [CNT_W-1:0] waitCnt_d;
  logic             prio_q;
  logic             prio_d;

  // Count consecutive refused MDU cycles and raise MDU priority once the limit is hit.
  always_comb begin
    waitCnt_d = waitCnt_q;
    prio_d    = prio_q;
    if (mduXfer || !mdu_valid_i) begin
      waitCnt_d = '0;
    end else if (waitCnt_q < WaitMax) begin
      waitCnt_d = waitCnt_q + 1'b1;
    end
    if (mduXfer) begin
      prio_d = 1'b0;
    end else if (waitCnt_d == WaitMax) begin
      prio_d = 1'b1;
    end
  end

  // Wait counter and priority flag registers.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      waitCnt_q <= '0;
      prio_q    <= 1'b0;
    end else begin
      waitCnt_q <= waitCnt_d;
      prio_q    <= prio_d;
    end
  end

  assign prioActive = prio_q;
`else
  // Without the guard WB always wins and the MDU simply waits for a free cycle.
  assign prioActive = 1'b0;
`endif

  // Arbitration: WB wins normally; with MDU priority the pipeline is frozen and WB ignored.
  always_comb begin
    grantWb  = 1'b0;
    grantMdu = 1'b0;
    stallInt = 1'b0;
    if (prioActive) begin
      grantMdu = mduReq;
      stallInt = 1'b1;
    end else begin
      grantWb  = wbReq;
      grantMdu = mduReq & ~wbReq;
    end
  end

  // A handshake completes whenever the MDU is valid and granted.
  always_comb begin
    mduXfer = mdu_valid_i & grantMdu;
  end

  // Drive the write port from the winner; an MDU result to r0 is accepted but not written.
  always_comb begin
    portWe   = 1'b0;
    portReg  = 5'd0;
    portData = 32'd0;
    if (grantWb) begin
      portWe   = 1'b1;
      portReg  = wb_rd_i;
      portData = wb_data_i;
    end else if (grantMdu) begin
      portWe   = (mdu_rd_i != 5'd0);
      portReg  = mdu_rd_i;
      portData = mdu_data_i;
    end
  end

  // Hazard on any pending source or a pending issue destination; no same-cycle bypass.
  always_comb begin
    hazardInt = pending_q[rs_i] | pending_q[rt_i] | (issue_i & pending_q[issue_rd_i]);
  end

  // Scoreboard next state: clear on MDU transfer, then set on accepted issue so set wins.
  always_comb begin
    issueAccept = issue_i & (issue_rd_i != 5'd0) & ~hazardInt;
    pending_d   = pending_q;
    if (mduXfer) begin
      pending_d[mdu_rd_i] = 1'b0;
    end
    if (issueAccept) begin
      pending_d[issue_rd_i] = 1'b1;
    end
    pending_d[0] = 1'b0;
  end

  // Scoreboard register; reset drops every in-flight entry.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      pending_q <= '0;
    end else begin
      pending_q <= pending_d;
    end
  end

  // Outputs are forced to zero while reset is asserted, independent of the inputs.
  always_comb begin
    mdu_ready_o = rst_n_i & grantMdu;
    stall_o     = rst_n_i & stallInt;
    hazard_o    = rst_n_i & hazardInt;
    RegWrite_o  = rst_n_i & portWe;
    WriteReg_o  = rst_n_i ? portReg : 5'd0;
    WriteData_o = rst_n_i ? portData : 32'd0;
    pending_o   = pending_q;
  end

endmodule

// File: tb/tb_regfile_wport_arbiter.sv
// Testbench for regfile_wport_arbiter: table-driven cycle vectors plus hand-written
// sequences for starvation and mid-operation reset. Expected outputs are queued when
// a cycle's stimulus is applied and popped when the outputs are sampled mid-cycle.
// Guard-specific expectations follow REGARB_STARVE_GUARD_EN.
module tb_regfile_wport_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_n_i;
  logic        wb_we_i;
  logic [4:0]  wb_rd_i;
  logic [31:0] wb_data_i;
  logic        mdu_valid_i;
  logic [4:0]  mdu_rd_i;
  logic [31:0] mdu_data_i;
  logic        mdu_ready_o;
  logic        issue_i;
  logic [4:0]  issue_rd_i;
  logic [4:0]  rs_i;
  logic [4:0]  rt_i;
  logic        hazard_o;
  logic        stall_o;
  logic        RegWrite_o;
  logic [4:0]  WriteReg_o;
  logic [31:0] WriteData_o;
  logic [31:0] pending_o;

  regfile_wport_arbiter #(.MAX_WAIT(4), .CNT_W(4)) dut (
    .clk_i       (clk_i),
    .rst_n_i     (rst_n_i),
    .wb_we_i     (wb_we_i),
    .wb_rd_i     (wb_rd_i),
    .wb_data_i   (wb_data_i),
    .mdu_valid_i (mdu_valid_i),
    .mdu_rd_i    (mdu_rd_i),
    .mdu_data_i  (mdu_data_i),
    .mdu_ready_o (mdu_ready_o),
    .issue_i     (issue_i),
    .issue_rd_i  (issue_rd_i),
    .rs_i        (rs_i),
    .rt_i        (rt_i),
    .hazard_o    (hazard_o),
    .stall_o     (stall_o),
    .RegWrite_o  (RegWrite_o),
    .WriteReg_o  (WriteReg_o),
    .WriteData_o (WriteData_o),
    .pending_o   (pending_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    string       name;
    logic        wbWe;
    logic [4:0]  wbRd;
    logic [31:0] wbData;
    logic        mduValid;
    logic [4:0]  mduRd;
    logic [31:0] mduData;
    logic        issue;
    logic [4:0]  issueRd;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic        expReady;
    logic        expHazard;
    logic        expStall;
    logic        expRegWrite;
    logic [4:0]  expWriteReg;
    logic [31:0] expWriteData;
    logic [31:0] expPending;
    logic        chkData;
  } vec_t;

  localparam int NumVec = 22;

  vec_t tbl [NumVec];
  vec_t expQ [$];
  int   compared   = 0;
  int   mismatched = 0;

  function automatic vec_t mk(
    input string name,
    input logic wbWe, input logic [4:0] wbRd, input logic [31:0] wbData,
    input logic mduValid, input logic [4:0] mduRd, input logic [31:0] mduData,
    input logic issue, input logic [4:0] issueRd, input logic [4:0] rs, input logic [4:0] rt,
    input logic expReady, input logic expHazard, input logic expStall, input logic expRegWrite,
    input logic [4:0] expWriteReg, input logic [31:0] expWriteData, input logic [31:0] expPending,
    input logic chkData);
    vec_t v;
    v.name = name;
    v.wbWe = wbWe; v.wbRd = wbRd; v.wbData = wbData;
    v.mduValid = mduValid; v.mduRd = mduRd; v.mduData = mduData;
    v.issue = issue; v.issueRd = issueRd; v.rs = rs; v.rt = rt;
    v.expReady = expReady; v.expHazard = expHazard; v.expStall = expStall;
    v.expRegWrite = expRegWrite; v.expWriteReg = expWriteReg;
    v.expWriteData = expWriteData; v.expPending = expPending;
    v.chkData = chkData;
    return v;
  endfunction

  task automatic checkField(input string tag, input string field,
                            input logic [31:0] act, input logic [31:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("[TB] FAIL %s.%s actual=0x%0h required=0x%0h", tag, field, act, req);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    wb_we_i     = v.wbWe;
    wb_rd_i     = v.wbRd;
    wb_data_i   = v.wbData;
    mdu_valid_i = v.mduValid;
    mdu_rd_i    = v.mduRd;
    mdu_data_i  = v.mduData;
    issue_i     = v.issue;
    issue_rd_i  = v.issueRd;
    rs_i        = v.rs;
    rt_i        = v.rt;
    expQ.push_back(v);
  endtask

  task automatic checkOutput();
    vec_t e;
    if (expQ.size() == 0) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL scoreboard actual=empty required=entry");
    end else begin
      e = expQ.pop_front();
      checkField(e.name, "mdu_ready", {31'd0, mdu_ready_o}, {31'd0, e.expReady});
      checkField(e.name, "hazard",    {31'd0, hazard_o},    {31'd0, e.expHazard});
      checkField(e.name, "stall",     {31'd0, stall_o},     {31'd0, e.expStall});
      checkField(e.name, "RegWrite",  {31'd0, RegWrite_o},  {31'd0, e.expRegWrite});
      checkField(e.name, "WriteReg",  {27'd0, WriteReg_o},  {27'd0, e.expWriteReg});
      if (e.chkData) begin
        checkField(e.name, "WriteData", WriteData_o, e.expWriteData);
      end
      checkField(e.name, "pending",   pending_o,           e.expPending);
    end
  endtask

  task automatic runVec(input vec_t v);
    applyStimulus(v);
    @(negedge clk_i);
    checkOutput();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t v;

    //            name        we rd  wdata         mv rd  mdata         is ird rs rt  rdy hz st rw wr  wdata         pend           chk
    tbl[0]  = mk("idle0",     0, 0,  32'h0,        0, 0,  32'h0,        0, 0,  0, 0,  0, 0, 0, 0, 0,  32'h0,        32'h0,         1);
    tbl[1]  = mk("iss5",      0, 0,  32'h0,        0, 0,  32'h0,        1, 5,  0, 0,  0, 0, 0, 0, 0,  32'h0,        32'h0,         1);
    tbl[2]  = mk("mdu5",      0, 0,  32'h0,        1, 5,  32'hDEADBEEF, 0, 0,  0, 0,  1, 0, 0, 1, 5,  32'hDEADBEEF, 32'h20,        1);
    tbl[3]  = mk("clr5",      0, 0,  32'h0,        0, 0,  32'h0,        0, 0,  0, 0,  0, 0, 0, 0, 0,  32'h0,        32'h0,         1);
    tbl[4]  = mk("wbonly",    1, 31, 32'hCAFEF00D, 0, 0,  32'h0,        0, 0,  0, 0,  0, 0, 0, 1, 31, 32'hCAFEF00D, 32'h0,         1);
    tbl[5]  = mk("iss9",      0, 0,  32'h0,        0, 0,  32'h0,        1, 9,  0, 0,  0, 0, 0, 0, 0,  32'h0,        32'h0,         1);
    tbl[6]  = mk("raw9",      0, 0,  32'h0,        0, 0,  32'h0,        0, 0,  9, 0,  0, 1, 0, 0, 0,  32'h0,        32'h200,       1);
    tbl[7]  = mk("raw9mdu",   0, 0,  32'h0,        1, 9,  32'h99,       0, 0,  9, 0,  1, 1, 0, 1, 9,  32'h99,       32'h200,       1);
    tbl[8]  = mk("raw9clr",   0, 0,  32'h0,        0, 0,  32'h0,        0, 0,  9, 0,  0, 0, 0, 0, 0,  32'h0,        32'h0,         1);
    tbl[9]  = mk("iss4",      0, 0,  32'h0,        0, 0,  32'h0,        1, 4,  0, 0,  0, 0, 0, 0, 0,  32'h0,        32'h0,         1);
    tbl[10] = mk("waw4",      0, 0,  32'h0,        0, 0,  32'h0,        1, 4,  0, 0,  0, 1, 0, 0, 0,  32'h0,        32'h10,        1);
    tbl[11] = mk("issblk",    0, 0,  32'h0,        0, 0,  32'h0,        1, 12, 4, 0,  0, 1, 0, 0, 0,  32'h0,        32'h10,        1);
    tbl[12] = mk("rt4",       0, 0,  32'h0,        0, 0,  32'h0,        0, 0,  0, 4,  0, 1, 0, 0, 0,  32'h0,        32'h10,        1);
    tbl[13] = mk("collide",   1, 3,  32'h11,       1, 7,  32'h77,       0, 0,  0, 0,  0, 0, 0, 1, 3,  32'h11,       32'h10,        1);
    tbl[14] = mk("wbr0",      1, 0,  32'hAA,       1, 7,  32'h77,       0, 0,  0, 0,  1, 0, 0, 1, 7,  32'h77,       32'h10,        1);
    tbl[15] = mk("mdur0",     0, 0,  32'h0,        1, 0,  32'h55,       0, 0,  0, 0,  1, 0, 0, 0, 0,  32'h0,        32'h10,        0);
    tbl[16] = mk("setwins",   0, 0,  32'h0,        1, 6,  32'h66,       1, 6,  0, 0,  1, 0, 0, 1, 6,  32'h66,       32'h10,        1);
    tbl[17] = mk("idle17",    0, 0,  32'h0,        0, 0,  32'h0,        0, 0,  0, 0,  0, 0, 0, 0, 0,  32'h0,        32'h50,        1);
    tbl[18] = mk("mdu4",      0, 0,  32'h0,        1, 4,  32'h44,       0, 0,  0, 0,  1, 0, 0, 1, 4,  32'h44,       32'h50,        1);
    tbl[19] = mk("idle19",    0, 0,  32'h0,        0, 0,  32'h0,        0, 0,  0, 0,  0, 0, 0, 0, 0,  32'h0,        32'h40,        1);
    tbl[20] = mk("mdu6",      0, 0,  32'h0,        1, 6,  32'h60,       0, 0,  0, 0,  1, 0, 0, 1, 6,  32'h60,       32'h40,        1);
    tbl[21] = mk("idle21",    0, 0,  32'h0,        0, 0,  32'h0,        0, 0,  0, 0,  0, 0, 0, 0, 0,  32'h0,        32'h0,         1);

    // Reset state with busy inputs: every output must be zero.
    rst_n_i = 1'b0;
    applyStimulus(mk("rst0", 1, 3, 32'h11, 1, 5, 32'h55, 1, 5, 5, 5,
                     0, 0, 0, 0, 0, 32'h0, 32'h0, 1));
    #3;
    checkOutput();
    @(posedge clk_i);
    @(posedge clk_i);
    #1;
    rst_n_i = 1'b1;

    for (int i = 0; i < NumVec; i++) begin
      runVec(tbl[i]);
    end

    // Starvation: WB busy every cycle while the MDU holds r7.
    for (int c = 0; c < 4; c++) begin
      runVec(mk("starve", 1, 3, 32'h11, 1, 7, 32'h77, 0, 0, 0, 0,
                0, 0, 0, 1, 3, 32'h11, 32'h0, 1));
    end
`ifdef REGARB_STARVE_GUARD_EN
    runVec(mk("guardwin", 1, 3, 32'h11, 1, 7, 32'h77, 0, 0, 0, 0,
              1, 0, 1, 1, 7, 32'h77, 32'h0, 1));
    runVec(mk("guardrel", 1, 3, 32'h11, 0, 0, 32'h0, 0, 0, 0, 0,
              0, 0, 0, 1, 3, 32'h11, 32'h0, 1));
`else
    for (int c = 0; c < 4; c++) begin
      runVec(mk("noguard", 1, 3, 32'h11, 1, 7, 32'h77, 0, 0, 0, 0,
                0, 0, 0, 1, 3, 32'h11, 32'h0, 1));
    end
    runVec(mk("wbfree", 0, 0, 32'h0, 1, 7, 32'h77, 0, 0, 0, 0,
              1, 0, 0, 1, 7, 32'h77, 32'h0, 1));
`endif
    runVec(tbl[0]);

    // Reset mid-operation: pending[8] set and two refused MDU cycles counted.
    runVec(mk("iss8", 0, 0, 32'h0, 0, 0, 32'h0, 1, 8, 0, 0,
              0, 0, 0, 0, 0, 32'h0, 32'h0, 1));
    for (int c = 0; c < 2; c++) begin
      runVec(mk("pre_rst", 1, 3, 32'h11, 1, 7, 32'h77, 0, 0, 8, 0,
                0, 1, 0, 1, 3, 32'h11, 32'h100, 1));
    end
    applyStimulus(mk("midrst", 1, 3, 32'h11, 1, 7, 32'h77, 1, 8, 8, 0,
                     0, 0, 0, 0, 0, 32'h0, 32'h0, 1));
    #2;
    rst_n_i = 1'b0;
    #1;
    checkOutput();
    @(posedge clk_i);
    #1;
    rst_n_i = 1'b1;
    for (int c = 0; c < 3; c++) begin
      runVec(mk("post_rst", 1, 3, 32'h11, 1, 7, 32'h77, 0, 0, 8, 0,
                0, 0, 0, 1, 3, 32'h11, 32'h0, 1));
    end
    runVec(mk("post_idle", 0, 0, 32'h0, 1, 7, 32'h77, 0, 0, 8, 0,
              1, 0, 0, 1, 7, 32'h77, 32'h0, 1));
    v = tbl[0];
    runVec(v);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
